// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding and
// address-field geometry derived from XLEN / LINES / WORDS.
package icache_dm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_LINES  = 16;
    localparam int DEF_WORDS  = 4;
    localparam int BYTE_OFF_W = 2;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int xlen, input int lines, input int words);
        return xlen - $clog2(lines) - $clog2(words) - BYTE_OFF_W;
    endfunction

    localparam int DEF_OFF_W = off_w(DEF_WORDS);
    localparam int DEF_IDX_W = idx_w(DEF_LINES);
    localparam int DEF_TAG_W = tag_w(DEF_XLEN, DEF_LINES, DEF_WORDS);

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for icache_dm. Only the valid bits are reset; tag and
// data contents are meaningless until a line is installed.
module icache_array
    import icache_dm_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int LINES = DEF_LINES,
    parameter  int WORDS = DEF_WORDS,
    localparam int OFF_W = off_w(WORDS),
    localparam int IDX_W = idx_w(LINES),
    localparam int TAG_W = tag_w(XLEN, LINES, WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_word,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             inst_en,
    input  logic [IDX_W-1:0] inst_idx,
    input  logic [TAG_W-1:0] inst_tag,
    input  logic             clr_all
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [XLEN-1:0]  data_q [LINES][WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (inst_en) begin
            valid_q[inst_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx][wr_off] <= wr_data;
        end
        if (inst_en) begin
            tag_q[inst_idx] <= inst_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with in-order line refill.
// Define ICACHE_FLUSH_EN to add the flush_in port and deferred flush handling.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            core_valid_in,
    input  logic [XLEN-1:0] core_addr_in,
    output logic            core_ready_out,
    output logic [XLEN-1:0] core_data_out,
    output logic            mem_valid_out,
    output logic [XLEN-1:0] mem_addr_out,
    input  logic            mem_ready_in,
    input  logic [XLEN-1:0] mem_data_in
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic            flush_in
`endif
);

    localparam int OFF_W   = off_w(WORDS);
    localparam int IDX_W   = idx_w(LINES);
    localparam int TAG_W   = tag_w(XLEN, LINES, WORDS);
    localparam int IDX_LSB = BYTE_OFF_W + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS - 1);

    state_t           state_q;
    logic [OFF_W-1:0] cnt_q;
    logic             done_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [OFF_W-1:0] off_q;

    logic [OFF_W-1:0] core_off;
    logic [IDX_W-1:0] core_idx;
    logic [TAG_W-1:0] core_tag;
    logic             unused_addr_bits;

    logic [IDX_W-1:0] lk_idx;
    logic [OFF_W-1:0] lk_off;
    logic             lk_valid;
    logic [TAG_W-1:0] lk_tag;
    logic [XLEN-1:0]  lk_word;
    logic             hit;

    logic             fill_active;
    logic             wr_en;
    logic             inst_en;
    logic             flush_go;

    assign core_off         = core_addr_in[BYTE_OFF_W +: OFF_W];
    assign core_idx         = core_addr_in[IDX_LSB +: IDX_W];
    assign core_tag         = core_addr_in[TAG_LSB +: TAG_W];
    assign unused_addr_bits = ^core_addr_in[BYTE_OFF_W-1:0];

    // In IDLE the live request is looked up; afterwards the latched one is.
    assign lk_idx = (state_q == IDLE) ? core_idx : idx_q;
    assign lk_off = (state_q == IDLE) ? core_off : off_q;
    assign hit    = lk_valid && (lk_tag == core_tag);

    // done_q marks the install cycle: the line is complete, the bus is idle.
    assign fill_active   = (state_q == REFILL) && !done_q;
    assign wr_en         = fill_active && mem_ready_in;
    assign inst_en       = wr_en && (cnt_q == LAST_CNT);
    assign mem_valid_out = fill_active;
    assign mem_addr_out  = fill_active ? {tag_q, idx_q, cnt_q, 2'b00} : '0;

`ifdef ICACHE_FLUSH_EN
    logic flush_pend_q;
    assign flush_go = (state_q == IDLE) && (flush_in || flush_pend_q);
`else
    assign flush_go = 1'b0;
`endif

    icache_array #(
        .XLEN  (XLEN),
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk      (clock_in),
        .rst      (reset_in),
        .rd_idx   (lk_idx),
        .rd_off   (lk_off),
        .rd_valid (lk_valid),
        .rd_tag   (lk_tag),
        .rd_word  (lk_word),
        .wr_en    (wr_en),
        .wr_idx   (idx_q),
        .wr_off   (cnt_q),
        .wr_data  (mem_data_in),
        .inst_en  (inst_en),
        .inst_idx (idx_q),
        .inst_tag (tag_q),
        .clr_all  (flush_go)
    );

    always_ff @(posedge clock_in) begin
        if ((state_q == IDLE) && core_valid_in && !flush_go) begin
            tag_q <= core_tag;
            idx_q <= core_idx;
            off_q <= core_off;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            core_ready_out <= 1'b0;
            core_data_out  <= '0;
`ifdef ICACHE_FLUSH_EN
            flush_pend_q   <= 1'b0;
`endif
        end else begin
            core_ready_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_go) begin
`ifdef ICACHE_FLUSH_EN
                        flush_pend_q <= 1'b0;
`endif
                    end else if (core_valid_in) begin
                        if (hit) begin
                            state_q        <= RESP;
                            core_ready_out <= 1'b1;
                            core_data_out  <= lk_word;
                        end else begin
                            state_q <= REFILL;
                            cnt_q   <= '0;
                            done_q  <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (done_q) begin
                        state_q        <= RESP;
                        done_q         <= 1'b0;
                        core_ready_out <= 1'b1;
                        core_data_out  <= lk_word;
                    end else if (mem_ready_in) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef ICACHE_FLUSH_EN
            if (flush_in && (state_q != IDLE)) begin
                flush_pend_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hit, conflict, slow memory,
// reset mid-refill and (with ICACHE_FLUSH_EN) deferred flush.
module tb_icache_dm;

    localparam logic [31:0] OFS = 32'h1000_0000;

    logic        clk;
    logic        reset_in;
    logic        core_valid;
    logic [31:0] core_addr;
    logic        core_ready;
    logic [31:0] core_data;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        flush;

    int nvec  = 0;
    int nfail = 0;

    icache_dm #(
        .XLEN  (32),
        .LINES (16),
        .WORDS (4)
    ) dut (
        .clock_in       (clk),
        .reset_in       (reset_in),
        .core_valid_in  (core_valid),
        .core_addr_in   (core_addr),
        .core_ready_out (core_ready),
        .core_data_out  (core_data),
        .mem_valid_out  (mem_valid),
        .mem_addr_out   (mem_addr),
        .mem_ready_in   (mem_ready),
        .mem_data_in    (mem_data)
`ifdef ICACHE_FLUSH_EN
        ,
        .flush_in       (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One fetch with a zero/fixed-wait memory responder. Latency counts cycles
    // from the edge that samples valid to the cycle in which ready is high.
    task automatic fetch(input string tag, input logic [31:0] addr, input int waits,
                         input logic [31:0] exp_data, input int exp_words,
                         input int exp_lat, input int flush_at);
        int          words;
        int          waitc;
        int          lat;
        bit          got;
        logic [31:0] base;
        base  = addr & ~32'hF;
        words = 0;
        waitc = 0;
        lat   = 0;
        got   = 1'b0;
        @(negedge clk);
        core_valid = 1'b1;
        core_addr  = addr;
        mem_ready  = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            flush     = (c == flush_at);
            if (core_ready) begin
                got = 1'b1;
                lat = c;
            end else begin
                core_addr = ~addr;
                if (mem_valid) begin
                    check({tag, ".maddr"}, mem_addr, base + 32'(words * 4));
                    if (waitc == waits) begin
                        mem_ready = 1'b1;
                        mem_data  = mem_addr + OFS;
                        words++;
                        waitc = 0;
                    end else begin
                        waitc++;
                    end
                end
            end
        end
        check({tag, ".done"}, 32'(got), 32'd1);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, core_data, exp_data);
        check({tag, ".words"}, 32'(words), 32'(exp_words));
        core_valid = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        check({tag, ".pulse"}, 32'(core_ready), 32'd0);
    endtask

    initial begin
        reset_in   = 1'b1;
        core_valid = 1'b0;
        core_addr  = '0;
        mem_ready  = 1'b0;
        mem_data   = '0;
        flush      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(core_ready), 32'd0);
        check("rst.data", core_data, 32'd0);
        check("rst.mvalid", 32'(mem_valid), 32'd0);
        check("rst.maddr", mem_addr, 32'd0);
        reset_in = 1'b0;

        fetch("cold",     32'h0000_0104, 0, 32'h1000_0104, 4, 6,  0);
        fetch("hit",      32'h0000_010C, 0, 32'h1000_010C, 0, 1,  0);
        fetch("conflict", 32'h0000_0504, 0, 32'h1000_0504, 4, 6,  0);
        fetch("remiss",   32'h0000_0104, 0, 32'h1000_0104, 4, 6,  0);
        fetch("hit0",     32'h0000_0100, 0, 32'h1000_0100, 0, 1,  0);
        fetch("lastmiss", 32'h0000_01FC, 0, 32'h1000_01FC, 4, 6,  0);
        fetch("lasthit",  32'h0000_01F0, 0, 32'h1000_01F0, 0, 1,  0);
        fetch("slow",     32'h0000_2204, 3, 32'h1000_2204, 4, 18, 0);
        fetch("slowhit",  32'h0000_2208, 3, 32'h1000_2208, 0, 1,  0);

        // Reset after two words of the 0x340 refill.
        @(negedge clk);
        core_valid = 1'b1;
        core_addr  = 32'h0000_0340;
        @(negedge clk);
        check("rst2.mv0", 32'(mem_valid), 32'd1);
        check("rst2.ma0", mem_addr, 32'h0000_0340);
        mem_ready = 1'b1;
        mem_data  = 32'h1000_0340;
        @(negedge clk);
        check("rst2.mv1", 32'(mem_valid), 32'd1);
        check("rst2.ma1", mem_addr, 32'h0000_0344);
        mem_ready = 1'b1;
        mem_data  = 32'h1000_0344;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rst2.ma2", mem_addr, 32'h0000_0348);
        reset_in   = 1'b1;
        core_valid = 1'b0;
        #1;
        check("rst2.mvoff", 32'(mem_valid), 32'd0);
        check("rst2.maoff", mem_addr, 32'd0);
        @(negedge clk);
        reset_in = 1'b0;
        fetch("postrst", 32'h0000_0344, 0, 32'h1000_0344, 4, 6, 0);
        fetch("lostline", 32'h0000_0104, 0, 32'h1000_0104, 4, 6, 0);

`ifdef ICACHE_FLUSH_EN
        fetch("flushfill", 32'h0000_0200, 0, 32'h1000_0200, 4, 6, 3);
        fetch("flushmiss", 32'h0000_0200, 0, 32'h1000_0200, 4, 6, 0);
        fetch("flushhit",  32'h0000_0204, 0, 32'h1000_0204, 0, 1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
